program_counter: RTL and testbench
==================================

// Module: program_counter
// PURPOSE
//  - Holds the 32-bit byte address of the current instruction; drives the instruction-memory address.
//  - Each rising clk edge loads the next PC, selected by the control unit via pcControl:
//    sequential (+4), absolute jump, PC-relative branch, or register-indirect jump.
//  - Sits between the control/register-file stage and instruction memory in the single-cycle CPU.
// PARAMETERS
//  - RESET_VECTOR  32'h0000_0000  value loaded into pc while reset is asserted
//  - PC_STEP       32'd4          sequential increment in bytes
// PORTS
//  - clk           in   1   single clock; all state updates on the rising edge
//  - reset         in   1   asynchronous, active-low reset
//  - pcControl     in   2   next-PC select (encoding in BEHAVIOUR)
//  - jumpAddress   in   26  instruction[25:0], word index for absolute jump
//  - branchOffset  in   16  instruction[15:0], signed word offset for branch
//  - regAddress    in   32  register-file read data 1, target for jump-register
//  - pc            out  32  current instruction byte address (registered)
// BEHAVIOUR
//  - Reset: while reset==0, pc = RESET_VECTOR immediately, without waiting for clk.
//    Reset asserted mid-operation overrides any pending update.
//    First update occurs on the first rising clk after reset deasserts.
//  - pc_plus4 = pc + PC_STEP, modulo 2^32.
//  - pcControl encoding, applied on every rising clk edge (latency 1 cycle):
//    - 2'b00 SEQ:    pc <= pc_plus4
//    - 2'b01 JUMP:   pc <= {pc_plus4[31:28], jumpAddress, 2'b00}
//    - 2'b10 BRANCH: pc <= pc_plus4 + ({{14{branchOffset[15]}}, branchOffset, 2'b00})
//    - 2'b11 JR:     pc <= regAddress
//  - All arithmetic is 32-bit unsigned modulo 2^32. Overflow is not detected.
//    Example: 32'hFFFF_FFFC SEQ -> 32'h0000_0000.
//  - Branch offset is relative to pc_plus4; it is never relative to pc.
//  - There is no enable and no stall: pc updates on every clock edge.
//  - pc is a pure register output with no combinational path from any input.
//  - Inputs are sampled only at the clock edge. Glitches between edges have no effect.
//  - pc[1:0] stays 00 for all modes except JR with a misaligned regAddress.
//    In that case regAddress is loaded unchanged unless PC_ALIGN_CHECK_EN is defined.
// CONFIGURATION
//  - Macro PC_ALIGN_CHECK_EN.
//  - Defined:
//    - Adds output port pcAlignErr (1 bit).
//    - On a JR edge with regAddress[1:0] != 0: pc <= {regAddress[31:2], 2'b00} and pcAlignErr <= 1.
//    - Any other edge clears pcAlignErr to 0.
//    - Reset value of pcAlignErr is 0.
//  - Undefined: no extra port; JR loads regAddress verbatim.
// STRUCTURE
//  - Shared package pc_pkg: localparams PC_SEQ=2'b00, PC_JUMP=2'b01, PC_BRANCH=2'b10, PC_JR=2'b11.
//    Also holds width constants ADDR_W=32, JADDR_W=26, OFF_W=16.
//  - One combinational sub-module, pc_next_calc:
//    - Inputs: pc, pcControl, jumpAddress, branchOffset, regAddress.
//    - Output: next_pc (plus the alignment flag when the macro is defined).
//  - The top level holds only the async-reset register and its instance.
// TESTING
//  - Reset: hold reset=0 and toggle clk -> pc=0x00000000 throughout.
//    Assert reset mid-run at pc=0x40 -> pc=0 before the next clk edge.
//  - SEQ: release reset, pcControl=00 for 3 edges -> pc = 0x4, 0x8, 0xC.
//    From pc=0xFFFFFFFC -> 0x00000000.
//  - JUMP: pc=0x1000_0010, jumpAddress=26'h0000100, pcControl=01 -> pc=0x1000_0400.
//  - BRANCH: pc=0x20, branchOffset=16'h0003 -> pc=0x30.
//    pc=0x20, branchOffset=16'hFFFE -> pc=0x1C.
//  - JR: regAddress=0x0000_0ABC, pcControl=11 -> pc=0x0000_0ABC.
//    With PC_ALIGN_CHECK_EN and regAddress=0x0000_0ABE -> pc=0x0000_0ABC, pcAlignErr=1.
//    pcAlignErr returns to 0 on the next SEQ edge.
//  - Mode switching: SEQ, BRANCH, JUMP, JR on consecutive edges -> each pc matches the formula, latency exactly 1 cycle.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants for the program counter slice.
//   Next-PC select encodings (pcControl) and the address/field widths
//   used by program_counter and pc_next_calc.
package pc_pkg;

  localparam int unsigned ADDR_W  = 32;  // byte address width
  localparam int unsigned JADDR_W = 26;  // absolute-jump word index width
  localparam int unsigned OFF_W   = 16;  // branch word-offset width

  // Next-PC select, values fixed by the control unit's pcControl encoding.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_JUMP   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JR     = 2'b11
  } pc_ctrl_e;

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: purely combinational next-PC selection.
//   pc           in  ADDR_W   current instruction byte address
//   pcControl    in  2        next-PC select (pc_pkg::pc_ctrl_e)
//   jumpAddress  in  JADDR_W  word index for absolute jump
//   branchOffset in  OFF_W    signed word offset, relative to pc + PC_STEP
//   regAddress   in  ADDR_W   jump-register target
//   next_pc      out ADDR_W   value to load on the next clock edge
//   align_err    out 1        only with PC_ALIGN_CHECK_EN: JR target misaligned
// Macro PC_ALIGN_CHECK_EN: force-align JR targets and flag misalignment.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_STEP = 32'd4
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [1:0]         pcControl,
  input  logic [JADDR_W-1:0] jumpAddress,
  input  logic [OFF_W-1:0]   branchOffset,
  input  logic [ADDR_W-1:0]  regAddress,
`ifdef PC_ALIGN_CHECK_EN
  output logic               align_err,
`endif
  output logic [ADDR_W-1:0]  next_pc
);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branch_disp;

  assign pc_plus4    = pc + PC_STEP;
  // Sign-extended word offset converted to bytes.
  assign branch_disp = {{(ADDR_W-OFF_W-2){branchOffset[OFF_W-1]}}, branchOffset, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
  always_comb begin
    next_pc   = pc_plus4;
    align_err = 1'b0;
    case (pc_ctrl_e'(pcControl))
      PC_SEQ:    next_pc = pc_plus4;
      PC_JUMP:   next_pc = {pc_plus4[ADDR_W-1:JADDR_W+2], jumpAddress, 2'b00};
      PC_BRANCH: next_pc = pc_plus4 + branch_disp;
      PC_JR: begin
        next_pc = {regAddress[ADDR_W-1:2], 2'b00};
        align_err = (regAddress[1:0] != 2'b00);
      end
    endcase
  end
`else
  always_comb begin
    next_pc = pc_plus4;
    case (pc_ctrl_e'(pcControl))
      PC_SEQ:    next_pc = pc_plus4;
      PC_JUMP:   next_pc = {pc_plus4[ADDR_W-1:JADDR_W+2], jumpAddress, 2'b00};
      PC_BRANCH: next_pc = pc_plus4 + branch_disp;
      PC_JR:     next_pc = regAddress;
    endcase
  end
`endif

endmodule

// File: rtl/program_counter.sv
// program_counter: registered instruction byte address for the single-cycle CPU.
//   clk          in  1    rising-edge clock, pc updates on every edge
//   reset        in  1    asynchronous active-low reset, pc = RESET_VECTOR
//   pcControl    in  2    next-PC select: SEQ / JUMP / BRANCH / JR
//   jumpAddress  in  26   instruction[25:0]
//   branchOffset in  16   instruction[15:0]
//   regAddress   in  32   register-file read data 1
//   pc           out 32   current instruction byte address (register output)
//   pcAlignErr   out 1    only with PC_ALIGN_CHECK_EN: last JR was misaligned
// Macro PC_ALIGN_CHECK_EN enables the alignment check and the pcAlignErr port.
module program_counter
  import pc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] PC_STEP      = 32'd4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         pcControl,
  input  logic [JADDR_W-1:0] jumpAddress,
  input  logic [OFF_W-1:0]   branchOffset,
  input  logic [ADDR_W-1:0]  regAddress,
`ifdef PC_ALIGN_CHECK_EN
  output logic               pcAlignErr,
`endif
  output logic [ADDR_W-1:0]  pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

`ifdef PC_ALIGN_CHECK_EN
  logic align_err_q;
  logic align_err_d;
`endif

  pc_next_calc #(
    .PC_STEP (PC_STEP)
  ) u_next (
    .pc           (pc_q),
    .pcControl    (pcControl),
    .jumpAddress  (jumpAddress),
    .branchOffset (branchOffset),
    .regAddress   (regAddress),
`ifdef PC_ALIGN_CHECK_EN
    .align_err    (align_err_d),
`endif
    .next_pc      (pc_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= align_err_d;
    end
  end

  assign pcAlignErr = align_err_q;
`endif

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pcControl    = 2'b00;
  logic [25:0] jumpAddress  = '0;
  logic [15:0] branchOffset = '0;
  logic [31:0] regAddress   = '0;
  logic [31:0] pc;
`ifdef PC_ALIGN_CHECK_EN
  logic        pcAlignErr;
`endif

  int errors = 0;
  int checks = 0;

  program_counter #(
    .RESET_VECTOR (32'h0000_0000),
    .PC_STEP      (32'd4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pcControl    (pcControl),
    .jumpAddress  (jumpAddress),
    .branchOffset (branchOffset),
    .regAddress   (regAddress),
`ifdef PC_ALIGN_CHECK_EN
    .pcAlignErr   (pcAlignErr),
`endif
    .pc           (pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pc=%h", pc);
    $fatal(1, "watchdog");
  end

  // Drive inputs on the falling edge, then wait past the next rising edge.
  task automatic apply(input logic [1:0] c, input logic [25:0] j,
                       input logic [15:0] b, input logic [31:0] r);
    @(negedge clk);
    pcControl    = c;
    jumpAddress  = j;
    branchOffset = b;
    regAddress   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_immediate: pc=%h expected=%h", pc, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (pc !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: pc=%h expected=%h", i, pc, 32'h0);
      end
    end
  endtask

  task automatic test_seq;
    @(negedge clk);
    pcControl = 2'b00;
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (pc !== 32'(i * 4)) begin
        errors++;
        $display("FAIL seq[%0d]: pc=%h expected=%h", i, pc, 32'(i * 4));
      end
    end
    apply(2'b11, '0, '0, 32'hFFFF_FFFC);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_load: pc=%h expected=%h", pc, 32'hFFFF_FFFC);
    end
    apply(2'b00, '0, '0, '0);
    checks++;
    if (pc !== 32'h0000_0000) begin
      errors++;
      $display("FAIL seq_wrap: pc=%h expected=%h", pc, 32'h0);
    end
  endtask

  task automatic test_reset_midrun;
    apply(2'b11, '0, '0, 32'h0000_0040);
    checks++;
    if (pc !== 32'h0000_0040) begin
      errors++;
      $display("FAIL midrun_load: pc=%h expected=%h", pc, 32'h40);
    end
    @(negedge clk);
    pcControl = 2'b00;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL midrun_async_reset: pc=%h expected=%h", pc, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL midrun_reset_hold: pc=%h expected=%h", pc, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h4) begin
      errors++;
      $display("FAIL first_after_release: pc=%h expected=%h", pc, 32'h4);
    end
  endtask

  task automatic test_jump;
    apply(2'b11, '0, '0, 32'h1000_0010);
    apply(2'b01, 26'h0000100, '0, '0);
    checks++;
    if (pc !== 32'h1000_0400) begin
      errors++;
      $display("FAIL jump: pc=%h expected=%h", pc, 32'h1000_0400);
    end
    // pc_plus4 = 0xF000_0404 keeps its top nibble.
    apply(2'b11, '0, '0, 32'hF000_0400);
    apply(2'b01, 26'h3FF_FFFF, '0, '0);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL jump_high: pc=%h expected=%h", pc, 32'hFFFF_FFFC);
    end
  endtask

  task automatic test_branch;
    apply(2'b11, '0, '0, 32'h0000_0020);
    apply(2'b10, '0, 16'h0003, '0);
    checks++;
    if (pc !== 32'h0000_0030) begin
      errors++;
      $display("FAIL branch_fwd: pc=%h expected=%h", pc, 32'h30);
    end
    apply(2'b11, '0, '0, 32'h0000_0020);
    apply(2'b10, '0, 16'hFFFE, '0);
    checks++;
    if (pc !== 32'h0000_001C) begin
      errors++;
      $display("FAIL branch_back: pc=%h expected=%h", pc, 32'h1C);
    end
    // Most negative offset: 0x8000_0000 + 4 - 0x20000.
    apply(2'b11, '0, '0, 32'h8000_0000);
    apply(2'b10, '0, 16'h8000, '0);
    checks++;
    if (pc !== 32'h7FFE_0004) begin
      errors++;
      $display("FAIL branch_minneg: pc=%h expected=%h", pc, 32'h7FFE_0004);
    end
  endtask

  task automatic test_jr;
    apply(2'b11, '0, '0, 32'h0000_0ABC);
    checks++;
    if (pc !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL jr: pc=%h expected=%h", pc, 32'hABC);
    end
`ifdef PC_ALIGN_CHECK_EN
    checks++;
    if (pcAlignErr !== 1'b0) begin
      errors++;
      $display("FAIL jr_aligned_flag: pcAlignErr=%b expected=0", pcAlignErr);
    end
    apply(2'b11, '0, '0, 32'h0000_0ABE);
    checks++;
    if (pc !== 32'h0000_0ABC || pcAlignErr !== 1'b1) begin
      errors++;
      $display("FAIL jr_misaligned: pc=%h err=%b expected pc=%h err=1", pc, pcAlignErr, 32'hABC);
    end
    apply(2'b00, '0, '0, '0);
    checks++;
    if (pc !== 32'h0000_0AC0 || pcAlignErr !== 1'b0) begin
      errors++;
      $display("FAIL align_clear: pc=%h err=%b expected pc=%h err=0", pc, pcAlignErr, 32'hAC0);
    end
`else
    apply(2'b11, '0, '0, 32'h0000_0ABE);
    checks++;
    if (pc !== 32'h0000_0ABE) begin
      errors++;
      $display("FAIL jr_misaligned_verbatim: pc=%h expected=%h", pc, 32'hABE);
    end
`endif
  endtask

  task automatic test_back_to_back;
    apply(2'b11, '0, '0, 32'h0000_0100);
    apply(2'b00, '0, '0, '0);
    checks++;
    if (pc !== 32'h0000_0104) begin
      errors++;
      $display("FAIL b2b_seq: pc=%h expected=%h", pc, 32'h104);
    end
    apply(2'b10, '0, 16'h0010, '0);
    checks++;
    if (pc !== 32'h0000_0148) begin
      errors++;
      $display("FAIL b2b_branch: pc=%h expected=%h", pc, 32'h148);
    end
    apply(2'b01, 26'h3FF_FFFF, '0, '0);
    checks++;
    if (pc !== 32'h0FFF_FFFC) begin
      errors++;
      $display("FAIL b2b_jump: pc=%h expected=%h", pc, 32'h0FFF_FFFC);
    end
    apply(2'b11, '0, '0, 32'hDEAD_BEE0);
    checks++;
    if (pc !== 32'hDEAD_BEE0) begin
      errors++;
      $display("FAIL b2b_jr: pc=%h expected=%h", pc, 32'hDEAD_BEE0);
    end
  endtask

  // Input changes between edges must not reach pc.
  task automatic test_no_comb_path;
    apply(2'b11, '0, '0, 32'h0000_2000);
    @(negedge clk);
    pcControl  = 2'b11;
    regAddress = 32'h1234_5678;
    #1;
    checks++;
    if (pc !== 32'h0000_2000) begin
      errors++;
      $display("FAIL no_comb_path: pc=%h expected=%h", pc, 32'h2000);
    end
    #1 pcControl = 2'b00;
    regAddress = 32'h0;
    @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h0000_2004) begin
      errors++;
      $display("FAIL glitch_ignored: pc=%h expected=%h", pc, 32'h2004);
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_seq();
    test_reset_midrun();
    test_jump();
    test_branch();
    test_jr();
    test_back_to_back();
    test_no_comb_path();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
